async_in_sync_filter: RTL and testbench
=======================================

// Module: async_in_sync_filter
// PURPOSE
//   Destination-domain conditioner for one asynchronous input (button, strap, external status line).
//   Stages:
//     1. Brings the input into clk through an ASYNC_REG-tagged flop chain.
//     2. Rejects pulses shorter than FILTER_CNT clocks.
//     3. Emits one-cycle rise/fall pulses.
//     4. Counts qualified rising events for software visibility.
//   Sits between the pad/IBUF and control logic that needs a clean, single-clock level and edges.
// PARAMETERS
//   SYNC_STAGES  2   synchronizer depth; legal range >= 2
//   FILTER_CNT   8   consecutive clocks a new level must persist before acceptance; legal range >= 1
//   CNT_W        16  width of event_cnt
//   RST_VAL      0   reset value of synchronizer chain and filtered level (1'b0 or 1'b1)
// PORTS
//   clk         in   1      single clock; all logic on posedge
//   rst_n       in   1      asynchronous, active-low reset
//   async_in    in   1      raw asynchronous input, no timing relation to clk
//   clr_cnt     in   1      synchronous clear of event_cnt and cnt_ovf
//   sync_out    out  1      last synchronizer stage (unfiltered)
//   level_out   out  1      filtered level
//   rise_pulse  out  1      1-cycle pulse when level_out goes 0->1
//   fall_pulse  out  1      1-cycle pulse when level_out goes 1->0
//   event_cnt   out  CNT_W  count of rise_pulse events, wraps modulo 2^CNT_W
//   cnt_ovf     out  1      sticky: event_cnt wrapped since last clear/reset
// BEHAVIOUR
//   Reset (async assert, sync-released by system):
//     sync chain = RST_VAL; level_out = RST_VAL; filter count = 0;
//     rise_pulse = fall_pulse = 0; event_cnt = 0; cnt_ovf = 0.
//   Synchronizer:
//     SYNC_STAGES flops in series; every stage carries (* ASYNC_REG = "TRUE" *).
//     No logic between stages. No fanout except from the last stage.
//     sync_out = last stage. Latency is SYNC_STAGES edges from first capture.
//   Filter: counter fcnt, width $clog2(FILTER_CNT+1). Each edge:
//     - sync_out == level_out: fcnt <= 0.
//     - sync_out != level_out and fcnt == FILTER_CNT-1: level_out <= sync_out; fcnt <= 0.
//     - otherwise: fcnt <= fcnt+1.
//     The change is accepted on the FILTER_CNT-th consecutive mismatching edge.
//     Any return to the current level restarts the count.
//     Total latency async_in -> level_out: SYNC_STAGES + FILTER_CNT clocks (+1 capture uncertainty).
//     FILTER_CNT=1: level_out is sync_out delayed one clock.
//   Edges:
//     Registered, asserted in the same cycle level_out takes its new value.
//     rise_pulse and fall_pulse are never both 1. Both are 0 in every cycle without a level change.
//   Event counter:
//     - clr_cnt=1: event_cnt <= 0, cnt_ovf <= 0. clr_cnt wins over a coincident increment.
//     - Else the cycle after rise_pulse=1: event_cnt <= event_cnt+1.
//     - If event_cnt was all-ones when incremented: it wraps to 0 and cnt_ovf <= 1.
//     - cnt_ovf holds until clr_cnt or reset.
//   A leaving-reset mismatch (async_in != RST_VAL) is a normal level change and produces a pulse.
//   Reset mid-filter discards the partial count. No pulse is emitted on reset assertion.
// TESTING (SYNC_STAGES=2, FILTER_CNT=4, RST_VAL=0 unless noted)
//   1. async_in=1 held through reset; release rst_n
//        -> level_out rises 6 clocks after release; rise_pulse high exactly 1 cycle; event_cnt=1.
//   2. Level 0; async_in=1 for 3 clocks, then 0
//        -> sync_out shows 3-cycle pulse; level_out stays 0; no pulses; event_cnt unchanged.
//   3. async_in 0->1, held 10 clocks, then 1->0 held 10 clocks
//        -> rise_pulse once, then fall_pulse once, each 1 cycle; event_cnt +1; never both high.
//   4. CNT_W=3, apply 8 qualified rising events
//        -> event_cnt=0 and cnt_ovf=1 after the 8th; clr_cnt for 1 clock -> both 0.
//   5. clr_cnt asserted in the same cycle as rise_pulse -> event_cnt=0 next cycle, cnt_ovf=0.
//   6. Assert rst_n low while fcnt=2 during a 0->1 change
//        -> all outputs immediately at reset values; after release, qualification restarts from fcnt=0.

Source files
------------

// File: rtl/async_in_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : async_in_sync_filter
// Purpose  : Destination-domain conditioner for a single asynchronous input
//            (button, strap pin, external status line). The input is brought
//            into clk through a synchronizer chain, then glitch-filtered so
//            that a new level must persist for FILTER_CNT clocks before it is
//            accepted. The block emits one-cycle rise/fall pulses on accepted
//            changes and counts accepted rising events.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1      single clock, all logic on posedge
//   rst_n       in   1      asynchronous active-low reset
//   async_in    in   1      raw asynchronous input
//   clr_cnt     in   1      synchronous clear of event_cnt and cnt_ovf
//   sync_out    out  1      last synchronizer stage (unfiltered)
//   level_out   out  1      filtered level
//   rise_pulse  out  1      one-cycle pulse when level_out goes 0->1
//   fall_pulse  out  1      one-cycle pulse when level_out goes 1->0
//   event_cnt   out  CNT_W  count of rise_pulse events, wraps
//   cnt_ovf     out  1      sticky: event_cnt wrapped since last clear/reset
// Parameters
//   SYNC_STAGES  synchronizer depth (>= 2)
//   FILTER_CNT   consecutive clocks a new level must persist (>= 1)
//   CNT_W        width of event_cnt
//   RST_VAL      reset value of synchronizer chain and filtered level
// ============================================================================
module async_in_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_CNT  = 8,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_in,
  input  logic             clr_cnt,
  output logic             sync_out,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic             cnt_ovf
);

  // Filter counter only ever reaches FILTER_CNT-1, but is sized for
  // FILTER_CNT+1 codes so the FILTER_CNT=1 case still has a 1-bit counter.
  localparam int unsigned         c_FCNT_W    = $clog2(FILTER_CNT + 1);
  localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FILTER_CNT - 1);

  // --------------------------------------------------------------------------
  // Synchronizer chain. Stage 0 is the only flop that sees async_in; nothing
  // but the next stage loads any stage before the last one.
  // --------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Persistence filter and edge pulses.
  // r_fcnt counts consecutive edges on which the synchronized input differs
  // from the accepted level. The change is taken on the FILTER_CNT-th such
  // edge; any agreement in between restarts the count.
  // --------------------------------------------------------------------------
  logic [c_FCNT_W-1:0] r_fcnt;
  logic                r_level;
  logic                r_rise;
  logic                r_fall;
  logic                w_mismatch;
  logic                w_accept;

  assign w_mismatch = (sync_out != r_level);
  assign w_accept   = w_mismatch && (r_fcnt == c_FCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_level <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      // Pulses are registered alongside the level so they appear in the
      // same cycle level_out takes its new value; only one can be set
      // because sync_out has a single value on the accepting edge.
      r_rise <= w_accept &  sync_out;
      r_fall <= w_accept & ~sync_out;

      if (!w_mismatch) begin
        r_fcnt <= '0;
      end else if (w_accept) begin
        r_level <= sync_out;
        r_fcnt  <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign level_out  = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

  // --------------------------------------------------------------------------
  // Rising-event counter. It advances on the edge after rise_pulse is seen,
  // so a clear arriving on that same edge swallows the pending increment.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_event_cnt;
  logic             r_cnt_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event_cnt <= '0;
      r_cnt_ovf   <= 1'b0;
    end else if (clr_cnt) begin
      r_event_cnt <= '0;
      r_cnt_ovf   <= 1'b0;
    end else if (r_rise) begin
      r_event_cnt <= r_event_cnt + 1'b1;
      // All-ones before the increment means this one wraps to zero.
      if (&r_event_cnt) begin
        r_cnt_ovf <= 1'b1;
      end
    end
  end

  assign event_cnt = r_event_cnt;
  assign cnt_ovf   = r_cnt_ovf;

endmodule
`default_nettype wire

// File: tb/tb_async_in_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_in_sync_filter
// Purpose  : Self-checking bench for async_in_sync_filter. A window-based
//            reference model predicts level changes; predicted pulses go to a
//            scoreboard queue that a negedge monitor drains whenever the DUT
//            presents a pulse. Directed scenarios plus randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_in_sync_filter;

  localparam int   S       = 2;
  localparam int   F       = 4;
  localparam int   W       = 3;
  localparam int   WRAP    = 1 << W;
  localparam logic RSTV    = 1'b0;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         async_in = 1'b0;
  logic         clr_cnt  = 1'b0;
  logic         sync_out;
  logic         level_out;
  logic         rise_pulse;
  logic         fall_pulse;
  logic [W-1:0] event_cnt;
  logic         cnt_ovf;

  async_in_sync_filter #(
    .SYNC_STAGES (S),
    .FILTER_CNT  (F),
    .CNT_W       (W),
    .RST_VAL     (RSTV)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (async_in),
    .clr_cnt    (clr_cnt),
    .sync_out   (sync_out),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_cnt  (event_cnt),
    .cnt_ovf    (cnt_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Input samples reach the filter S edges after capture
  // (a plain delay queue). A level change happens on an edge when the last F
  // filter inputs all differ from the current level. Event count is kept as
  // the total number of rises since clear; DUT count is that modulo 2^W.
  // --------------------------------------------------------------------------
  typedef struct {
    int   eno;
    logic rise;
  } ev_t;

  ev_t  sbq[$];
  logic m_dly[$];
  logic m_win[$];
  int   m_edge;
  logic m_level;
  int   m_cnt;
  logic m_pend;

  task automatic model_reset();
    m_edge = 0;
    m_dly.delete();
    for (int i = 0; i < S; i++) m_dly.push_back(RSTV);
    m_win.delete();
    m_level = RSTV;
    m_cnt   = 0;
    m_pend  = 1'b0;
    sbq.delete();
  endtask

  initial begin
    logic fin;
    bit   all_diff;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_edge++;
        if (clr_cnt) m_cnt = 0;
        else if (m_pend) m_cnt++;
        m_pend = 1'b0;
        fin = m_dly.pop_front();
        m_dly.push_back(async_in);
        m_win.push_back(fin);
        if (m_win.size() > F) void'(m_win.pop_front());
        all_diff = (m_win.size() == F);
        foreach (m_win[i]) if (m_win[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
          m_level = fin;
          m_pend  = fin;
          sbq.push_back(ev_t'{eno: m_edge, rise: fin});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: checks every cycle on the falling edge.
  // --------------------------------------------------------------------------
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      chk("pulse_exclusive", {31'd0, rise_pulse & fall_pulse}, 0);
      if (rise_pulse || fall_pulse) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, rise_pulse, fall_pulse}, 0);
        end else begin
          ev = sbq.pop_front();
          chk("pulse_edge", m_edge, ev.eno);
          chk("pulse_dir", {31'd0, rise_pulse}, {31'd0, ev.rise});
        end
      end else if (sbq.size() > 0 && sbq[0].eno <= m_edge) begin
        ev = sbq.pop_front();
        chk("missed_pulse", {30'd0, rise_pulse, fall_pulse}, ev.rise ? 2 : 1);
      end
      chk("sync_out", {31'd0, sync_out}, {31'd0, m_dly[0]});
      chk("level_out", {31'd0, level_out}, {31'd0, m_level});
      chk("event_cnt", {29'd0, event_cnt}, m_cnt % WRAP);
      chk("cnt_ovf", {31'd0, cnt_ovf}, (m_cnt >= WRAP) ? 1 : 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic v, input int n);
    async_in = v;
    cyc(n);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n;
    int hi;
    int lv;
    int pl;
    int rises;
    int falls;
    int both;

    // 1. input high through reset, release and measure latency
    async_in = 1'b1;
    rst_n    = 1'b0;
    cyc(3);
    chk("t1_reset_level", {31'd0, level_out}, 0);
    chk("t1_reset_cnt", {29'd0, event_cnt}, 0);
    rst_n = 1'b1;
    n = 0;
    while (!level_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_rise_latency", n, 6);
    chk("t1_rise_pulse", {31'd0, rise_pulse}, 1);
    cyc(1);
    chk("t1_rise_width", {31'd0, rise_pulse}, 0);
    chk("t1_event_cnt", {29'd0, event_cnt}, 1);

    // 2. short 3-clock pulse from level 0 is rejected
    hold(1'b0, 10);
    hi = 0; lv = 0; pl = 0;
    for (int i = 0; i < 16; i++) begin
      async_in = (i < 3);
      @(negedge clk);
      hi += sync_out;
      lv += level_out;
      pl += rise_pulse + fall_pulse;
    end
    chk("t2_sync_width", hi, 3);
    chk("t2_level_stays", lv, 0);
    chk("t2_no_pulses", pl, 0);
    chk("t2_cnt_same", {29'd0, event_cnt}, 1);

    // 3. long high then long low
    rises = 0; falls = 0; both = 0;
    for (int i = 0; i < 20; i++) begin
      async_in = (i < 10);
      @(negedge clk);
      rises += rise_pulse;
      falls += fall_pulse;
      both  += rise_pulse & fall_pulse;
    end
    chk("t3_rises", rises, 1);
    chk("t3_falls", falls, 1);
    chk("t3_both", both, 0);
    chk("t3_cnt", {29'd0, event_cnt}, 2);

    // 4. counter wrap after 2^W qualified rises, then clear
    clr_cnt = 1'b1;
    cyc(1);
    clr_cnt = 1'b0;
    for (int i = 0; i < WRAP; i++) begin
      hold(1'b1, 7);
      hold(1'b0, 7);
    end
    chk("t4_wrap_cnt", {29'd0, event_cnt}, 0);
    chk("t4_wrap_ovf", {31'd0, cnt_ovf}, 1);
    clr_cnt = 1'b1;
    cyc(1);
    clr_cnt = 1'b0;
    chk("t4_clr_cnt", {29'd0, event_cnt}, 0);
    chk("t4_clr_ovf", {31'd0, cnt_ovf}, 0);

    // 5. clear coincident with rise_pulse
    hold(1'b1, 7);
    hold(1'b0, 7);
    async_in = 1'b1;
    n = 0;
    while (!rise_pulse && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rise_seen", {31'd0, rise_pulse}, 1);
    clr_cnt = 1'b1;
    cyc(1);
    clr_cnt = 1'b0;
    chk("t5_cnt", {29'd0, event_cnt}, 0);
    chk("t5_ovf", {31'd0, cnt_ovf}, 0);
    cyc(1);
    chk("t5_cnt_after", {29'd0, event_cnt}, 0);

    // 6. reset in the middle of qualification
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    async_in = 1'b1;
    cyc(4);
    chk("t6_pre_level", {31'd0, level_out}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_sync", {31'd0, sync_out}, 0);
    chk("t6_rst_level", {31'd0, level_out}, 0);
    chk("t6_rst_pulses", {30'd0, rise_pulse, fall_pulse}, 0);
    chk("t6_rst_cnt", {29'd0, event_cnt}, 0);
    chk("t6_rst_ovf", {31'd0, cnt_ovf}, 0);
    cyc(2);
    rst_n = 1'b1;
    n = 0;
    while (!level_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_restart_latency", n, 6);

    // Randomized segments with occasional clears and resets
    for (int s = 0; s < 1500; s++) begin
      int len;
      async_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        clr_cnt = ($urandom_range(0, 19) == 0);
        @(negedge clk);
      end
      clr_cnt = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
    end
    hold(async_in, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
